// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding, width limit and counter sizing for serial_adder
package serial_adder_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
  localparam int MAX_WIDTH = 32;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: combinational one-bit full adder
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one fa_cell reused LSB-first; SERIAL_ADDER_SUBTRACT_EN adds a sub port.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int CW = cnt_width(WIDTH);
  state_t state;
  logic [WIDTH-1:0] a_sr, b_sr, acc, acc_nx;
  logic [CW-1:0] cnt;
  logic carry, s, co, b_bit, cin0, accept, last;
`ifdef SERIAL_ADDER_SUBTRACT_EN
  logic sub_r;
  assign cin0  = sub;
  assign b_bit = b_sr[0] ^ sub_r;
  always_ff @(posedge clk)
    if (!rst_n) sub_r <= 1'b0;
    else if (accept) sub_r <= sub;
`else
  assign cin0  = 1'b0;
  assign b_bit = b_sr[0];
`endif
  assign busy   = state == SHIFT;
  assign done   = state == DONE;
  assign accept = start && state != SHIFT;
  assign last   = cnt == CW'(WIDTH - 1);
  assign acc_nx = WIDTH'({s, acc} >> 1);
  fa_cell u_fa (.x(a_sr[0]), .y(b_bit), .ci(carry), .s(s), .co(co));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
    end else if (accept) begin
      state <= SHIFT;
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin0;
      cnt   <= '0;
    end else if (busy) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      acc   <= acc_nx;
      carry <= co;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum   <= acc_nx;
        c_out <= co;
        state <= DONE;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table-driven scoreboard bench for serial_adder (WIDTH=8 and WIDTH=1 instances)
module tb_serial_adder;
  localparam int W = 8;
  logic clk = 0, rst_n = 0, start = 0, sub = 0;
  logic [W-1:0] a = '0, b = '0, sum;
  logic busy, done, c_out;
  logic start1 = 0, sub1 = 0, busy1, done1, c1;
  logic [0:0] a1 = '0, b1 = '0, sum1;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef SERIAL_ADDER_SUBTRACT_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .c_out(c_out));

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
`ifdef SERIAL_ADDER_SUBTRACT_EN
    .sub(sub1),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .c_out(c1));

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sb;
    logic [W-1:0] s;
    logic         c;
  } vec_t;
  vec_t vecs[$];
  logic [W:0] exp_q[$];
  int checks = 0, failures = 0;
  logic [W-1:0] last_sum = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [W:0] e;
    if (rst_n && done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("sum", sum, e[W-1:0]);
        chk("c_out", c_out, e[W]);
        last_sum = e[W-1:0];
      end
    end
  end

  task automatic run_op(input vec_t v);
    bit ok = 1, hold = 1;
    @(negedge clk);
    a = v.a; b = v.b; sub = v.sb; start = 1;
    exp_q.push_back({v.c, v.s});
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      start = 0;
      if (!busy || done) ok = 0;
      if (sum !== last_sum) hold = 0;
    end
    @(negedge clk);
    chk("done_latency", {busy, done}, 2'b01);
    chk("busy_window", ok, 1);
    chk("sum_hold", hold, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    bit quiet;
    vecs.push_back('{8'h3C, 8'h55, 1'b0, 8'h91, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
`ifdef SERIAL_ADDER_SUBTRACT_EN
    vecs.push_back('{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1});
    vecs.push_back('{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0});
    vecs.push_back('{8'h55, 8'h55, 1'b1, 8'h00, 1'b1});
    vecs.push_back('{8'h01, 8'h02, 1'b0, 8'h03, 1'b0});
`endif
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, sum, c_out}, '0);
    chk("reset_outputs_w1", {busy1, done1, sum1, c1}, '0);
    rst_n = 1;
    foreach (vecs[i]) run_op(vecs[i]);

    @(negedge clk);
    a = 8'h12; b = 8'h34; sub = 0; start = 1;
    exp_q.push_back({1'b0, 8'h46});
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done) break;
      a = 8'($urandom); b = 8'($urandom);
    end
    chk("held_done_seen", done, 1);
    chk("held_latency", n, W);
    a = 8'h80; b = 8'h80;
    exp_q.push_back({1'b1, 8'h00});
    @(negedge clk);
    start = 0;
    chk("b2b_accepted", {busy, done}, 2'b10);
    for (n = 1; n < 30; n++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("b2b_latency", n, W);
    @(negedge clk);

    a = 8'hF0; b = 8'h0F; start = 1;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("mid_reset", {busy, done, sum, c_out}, '0);
    last_sum = '0;
    rst_n = 1;
    quiet = 1;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) quiet = 0;
    end
    chk("no_done_after_reset", quiet, 1);
    run_op('{8'h01, 8'h02, 1'b0, 8'h03, 1'b0});

    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; start1 = 1;
    @(negedge clk);
    start1 = 0;
    chk("w1_busy", {busy1, done1}, 2'b10);
    @(negedge clk);
    chk("w1_done", {busy1, done1, sum1, c1}, 4'b0101);
    a1 = 1'b1; b1 = 1'b0; start1 = 1;
    @(negedge clk);
    start1 = 0;
    @(negedge clk);
    chk("w1_done2", {busy1, done1, sum1, c1}, 4'b0110);

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
